// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int unsigned MDU_W     = 32;
  localparam int unsigned MDU_ITERS = 32;
  localparam int unsigned MDU_CNT_W = $clog2(MDU_ITERS);

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CALC  = 2'b01,
    FIXUP = 2'b10
  } mdu_state_e;

  // Magnitude of a two's-complement value when en is set; raw value otherwise.
  function automatic logic [MDU_W-1:0] mdu_abs(input logic [MDU_W-1:0] x, input logic en);
    return (en && x[MDU_W-1]) ? (~x + MDU_W'(1)) : x;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the datapath: shift-add for multiply, restoring trial-subtract for divide.
module mdu_step #(
  parameter int unsigned W = 32
) (
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   operand,
  input  logic           bit_in,
  input  logic           is_div,
  output logic [2*W-1:0] acc_next
);

  logic [W:0]   mul_sum;
  logic [W:0]   shifted;
  logic [W-1:0] rem_sub;
  logic         fits;

  // Multiply adds into the upper half and shifts right; divide shifts a dividend
  // bit into the remainder and records the quotient bit in the low end.
  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + (bit_in ? {1'b0, operand} : (W+1)'(0));
    shifted  = {acc[2*W-1:W], bit_in};
    fits     = (shifted >= {1'b0, operand});
    rem_sub  = shifted[W-1:0] - operand;
    acc_next = {mul_sum, acc[W-1:1]};
    if (is_div) begin
      acc_next = {(fits ? rem_sub : shifted[W-1:0]), acc[W-2:0], fits};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned AW = 2 * WIDTH;

  mdu_state_e           state;
  mdu_op_e              op_q;
  logic [MDU_CNT_W-1:0] cnt;
  logic [AW-1:0]        acc;
  logic [WIDTH-1:0]     opnd;
  logic [WIDTH-1:0]     shreg;
  logic                 neg_res;
  logic                 neg_rem;
  logic                 dbz;

  logic                 is_div_c;
  logic                 start_signed_c;
  logic                 start_div_c;
  logic                 bit_in_c;
  logic [AW-1:0]        acc_next_c;
  logic [WIDTH-1:0]     quo_c;
  logic [WIDTH-1:0]     rem_c;

  // Operation decode for the op in flight and for the op being launched.
  always_comb begin
    is_div_c       = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
    start_signed_c = (op == MDU_MULT) || (op == MDU_DIV);
    start_div_c    = (op == MDU_DIV) || (op == MDU_DIVU);
    bit_in_c       = is_div_c ? shreg[WIDTH-1] : shreg[0];
    quo_c          = acc[WIDTH-1:0];
    rem_c          = acc[AW-1:WIDTH];
  end

  mdu_step #(.W(WIDTH)) u_step (
    .acc      (acc),
    .operand  (opnd),
    .bit_in   (bit_in_c),
    .is_div   (is_div_c),
    .acc_next (acc_next_c)
  );

  // Control FSM, operand capture, iteration and HI/LO writeback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= MDU_MULT;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      shreg   <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dbz     <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= CALC;
            busy    <= 1'b1;
            op_q    <= mdu_op_e'(op);
            opnd    <= start_div_c ? mdu_abs(b, start_signed_c) : mdu_abs(a, start_signed_c);
            shreg   <= start_div_c ? mdu_abs(a, start_signed_c) : mdu_abs(b, start_signed_c);
            neg_res <= start_signed_c & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem <= start_signed_c & a[WIDTH-1];
            dbz     <= start_div_c & (b == '0);
            acc     <= '0;
            cnt     <= MDU_CNT_W'(MDU_ITERS - 1);
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          acc   <= acc_next_c;
          shreg <= is_div_c ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
          cnt   <= cnt - MDU_CNT_W'(1);
          if (cnt == '0) state <= FIXUP;
        end
        FIXUP: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (is_div_c) begin
            lo <= dbz ? '1 : (neg_res ? (~quo_c + WIDTH'(1)) : quo_c);
            hi <= neg_rem ? (~rem_c + WIDTH'(1)) : rem_c;
          end else begin
            {hi, lo} <= neg_res ? (~acc + AW'(1)) : acc;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_hi = '0;
  logic [31:0] ref_lo = '0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Returns {hi, lo} from the architectural definition of each op.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, p, q, r;
    logic [63:0] res, qv, rv;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    res = '0;
    case (o)
      2'b00: begin p = sx * sy; res = p; end
      2'b01: res = {32'h0, x} * {32'h0, y};
      2'b10: begin
        if (y == 32'h0) res = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy; r = sx % sy;
          qv = q; rv = r;
          res = {rv[31:0], qv[31:0]};
        end
      end
      default: begin
        if (y == 32'h0) res = {x, 32'hFFFF_FFFF};
        else res = {x % y, x / y};
      end
    endcase
    return res;
  endfunction

  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit poke, input bit with_wr, input string tag);
    logic [63:0] exp;
    int          cyc;
    bit          overlap;
    bit          hold_ok;
    exp = model(o, x, y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    if (with_wr) begin hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678; end
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
    cyc = 0; overlap = 1'b0; hold_ok = 1'b1;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (done !== 1'b0) overlap = 1'b1;
      if (hi !== ref_hi || lo !== ref_lo) hold_ok = 1'b0;
      if (poke && cyc == 5) begin
        start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check_eq({tag, " busy_cycles"}, 64'(cyc), 64'd33);
    check_eq({tag, " done_while_busy"}, 64'(overlap), 64'd0);
    check_eq({tag, " hilo_held"}, 64'(hold_ok), 64'd1);
    check_eq({tag, " done_pulse"}, 64'(done), 64'd1);
    check_eq({tag, " result"}, {hi, lo}, exp);
    ref_hi = exp[63:32];
    ref_lo = exp[31:0];
    @(negedge clk);
    check_eq({tag, " done_cleared"}, {62'd0, done, busy}, 64'd0);
  endtask

  task automatic wr_hilo(input bit h, input bit l, input logic [31:0] d, input string tag);
    @(negedge clk);
    hi_we = h; lo_we = l; wdata = d;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    if (h) ref_hi = d;
    if (l) ref_lo = d;
    check_eq({tag, " hilo"}, {hi, lo}, {ref_hi, ref_lo});
  endtask

  initial begin
    bit          saw_done;
    logic [1:0]  ro;
    logic [31:0] rx, ry;

    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    check_eq("reset_state", {28'd0, busy, done, 2'b00, hi, lo}, 64'd0);
    reset = 1'b0;

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "multu_max");
    do_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, "mult_neg3x5");
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "div_neg7by2");
    do_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, "divu_100by7");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_ovf");
    do_op(2'b11, 32'd5, 32'd0, 1'b0, 1'b0, "divu_by0");
    do_op(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0, "div_neg_by0");
    do_op(2'b10, 32'd1000, 32'hFFFF_FFFD, 1'b1, 1'b0, "div_poke");

    wr_hilo(1'b1, 1'b1, 32'h1234_5678, "mthi_mtlo");
    wr_hilo(1'b1, 1'b0, 32'hCAFE_0001, "mthi_only");
    wr_hilo(1'b0, 1'b1, 32'h0BAD_F00D, "mtlo_only");
    do_op(2'b01, 32'd3, 32'd9, 1'b0, 1'b1, "start_wins");

    // Reset in the middle of a multiply.
    wr_hilo(1'b1, 1'b1, 32'hAAAA_5555, "pre_reset");
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'h1234_5678; b = 32'h8765_4321;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("mid_reset_state", {30'd0, busy, done, hi}, 64'd0);
    check_eq("mid_reset_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    ref_hi = '0; ref_lo = '0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    check_eq("no_done_after_reset", 64'(saw_done), 64'd0);
    do_op(2'b01, 32'd6, 32'd7, 1'b0, 1'b0, "multu_6x7");

    // Randomized ops with corner operands mixed in.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 32'h0;
        1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
        2: ry = 32'($urandom_range(1, 15));
        3: rx = 32'h8000_0000;
        default: ;
      endcase
      do_op(ro, rx, ry, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), "rand_op");
      if ($urandom_range(0, 3) == 0)
        wr_hilo(1'($urandom), 1'($urandom), $urandom, "rand_wr");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit for the execute stage of the pipelined MIPS core, alongside the ALU and fed the same forwarded operands. Runs MULT, MULTU, DIV and DIVU over multiple cycles into architectural HI/LO registers. Raises `busy` so the hazard logic stalls decode until the result is ready. Also services MTHI/MTLO writes and supplies HI/LO for MFHI/MFLO.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width; only 32 is supported.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  launch an operation; sampled only while `busy`=0.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  32  rs operand; multiplicand or dividend.
- `b`  in  32  rt operand; multiplier or divisor.
- `hi_we`  in  1  MTHI write strobe.
- `lo_we`  in  1  MTLO write strobe.
- `wdata`  in  32  MTHI/MTLO data.
- `busy`  out  1  operation in flight; decode must stall MULT/DIV/MFHI/MFLO.
- `done`  out  1  one-cycle pulse when HI/LO take a new result.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- FSM states:
  - IDLE → CALC on `start`.
  - CALC: 32 iterations, then → FIXUP.
  - FIXUP → IDLE.
- IDLE + `start`:
  - latch `op`.
  - latch |a| and |b| for signed ops, raw a and b for unsigned ops.
  - latch the result sign: a[31]^b[31] for the product/quotient, a[31] for the remainder.
  - clear the 64-bit accumulator and load the iteration counter with 31.
- CALC, multiply: radix-2 shift-add, one multiplier bit per cycle, LSB first.
- CALC, divide: restoring division, one quotient bit per cycle, MSB first; the remainder is held in the upper half of the accumulator.
- FIXUP:
  - apply two's-complement negation per the latched signs.
  - multiply: write {hi,lo} = 64-bit product.
  - divide: write lo = quotient, hi = remainder.
- Signed divide truncates toward zero; the remainder takes the dividend's sign (e.g. −7/2 gives lo=−3, hi=−1).
- Divide by zero, any sign: hi = a (original), lo = 32'hFFFF_FFFF. Full 33 cycles, no trap.
- DIV 32'h8000_0000 / −1: lo = 32'h8000_0000, hi = 0.
- MULT/MULTU never overflow; the full 64-bit result is kept.
- In IDLE only: `hi_we` loads hi ← `wdata`, `lo_we` loads lo ← `wdata`; both may assert in the same cycle.
- While `busy`=1:
  - `start`, `hi_we` and `lo_we` are ignored.
  - hi/lo keep their old values until FIXUP.
- `start` together with `hi_we`/`lo_we` in IDLE: `start` wins and the writes are dropped.
- Operands are captured at start. Later changes to `a`/`b`/`op` do not affect the operation in flight.

## Timing
- Reset values: `busy`=0, `done`=0, hi=0, lo=0, state=IDLE, counter=0.
- Edge E0 samples `start`; `busy`=1 from just after E0.
- Edges E1–E32 are the CALC iterations. Edge E33 is FIXUP and writes hi/lo.
- After E33: `busy`=0, `done`=1 for exactly one cycle, and hi/lo show the result.
- A new `start` is accepted at E34 at the earliest; back-to-back ops therefore start 34 cycles apart.
- Latency is fixed at 33 cycles for every op and operand value, including divide by zero.
- `busy` and `done` are registered outputs; `done` and `busy` are never both 1.
- MTHI/MTLO writes are visible on hi/lo one cycle after the strobe edge.
- `reset` asserted mid-operation returns to IDLE at once. hi/lo clear to 0 and no `done` is produced.

## Structure
- Package `mdu_pkg` holds:
  - op encodings: `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`.
  - state enum: IDLE, CALC, FIXUP.
  - `MDU_ITERS` = 32.
- One sub-module, `mdu_step`: combinational single-iteration datapath. Inputs: accumulator, operand, and an is_div flag. Output: next accumulator (add-shift for multiply, trial-subtract-shift for divide). The FSM, counter, sign handling and HI/LO registers stay in `mul_div_unit`.

## Test plan
- MULTU 32'hFFFF_FFFF × 32'hFFFF_FFFF → after 33 cycles hi=32'hFFFF_FFFE, lo=32'h0000_0001; `done` pulses once.
- MULT −3 × 5 → hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF1. DIV −7 / 2 → lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
- DIVU 100 / 7 → lo=14, hi=2. DIV 32'h8000_0000 / −1 → lo=32'h8000_0000, hi=0. DIVU 5 / 0 → hi=5, lo=32'hFFFF_FFFF.
- `busy` window: during a DIV, pulse `start`, `hi_we`, `lo_we` with `wdata`=32'hDEAD_BEEF → all ignored; result unchanged; `busy` exactly 33 cycles.
- `hi_we`+`lo_we` in IDLE, `wdata`=32'h1234_5678 → hi=lo=32'h1234_5678 next cycle. Same cycle as `start` → writes dropped, op runs.
- Assert `reset` at iteration 10 of a MULT → `busy`=0, hi=lo=0, no `done`. Next MULTU 6×7 → lo=42, hi=0.
